xcorr_lag_accum: RTL and testbench

- Downstream stage of the ADDMUL product path in the cross-correlation datapath.
- Consumes the 16-bit signed product stream and sums WINDOW consecutive products into one correlation value per lag.
- Steps through NLAGS lags per sweep, emits each lag's sum, and reports the peak (maximum) value and its lag index at the end of each sweep.

---
 rtl/xcorr_pkg.sv | 24 ++
 rtl/xcorr_peak_track.sv | 40 ++++
 rtl/xcorr_lag_accum.sv | 174 +++++++++++++++++
 tb/tb_xcorr_lag_accum.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_pkg.sv
// Shared types, widths and helpers for the cross-correlation lag accumulator
// and its peak tracker.
package xcorr_pkg;

  localparam int PROD_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef logic signed [PROD_W-1:0] prod_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xcorr_peak_track.sv
// Signed running-maximum register with its index. best_*_o reflects the
// compare including the current candidate, so a caller can capture it same-cycle.
module xcorr_peak_track #(
  parameter int ACC_W = 24,
  parameter int LAG_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    upd_i,
  input  logic                    first_i,
  input  logic signed [ACC_W-1:0] val_i,
  input  logic        [LAG_W-1:0] idx_i,
  output logic signed [ACC_W-1:0] best_val_o,
  output logic        [LAG_W-1:0] best_idx_o
);

  logic signed [ACC_W-1:0] run_val_q;
  logic        [LAG_W-1:0] run_idx_q;
  logic                    take;

  // Strict compare: a tie keeps the earlier index.
  assign take       = first_i || (val_i > run_val_q);
  assign best_val_o = take ? val_i : run_val_q;
  assign best_idx_o = take ? idx_i : run_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_val_q <= '0;
      run_idx_q <= '0;
    end else if (clr_i) begin
      run_val_q <= '0;
      run_idx_q <= '0;
    end else if (upd_i) begin
      run_val_q <= best_val_o;
      run_idx_q <= best_idx_o;
    end
  end

endmodule

// File: rtl/xcorr_lag_accum.sv
// Sums WINDOW signed products per lag over NLAGS lags, emitting each lag sum
// and the sweep's peak value/lag at sweep end.
module xcorr_lag_accum
  import xcorr_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int NLAGS  = 64,
  parameter int ACC_W  = 24,
  parameter int LAG_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     prod_valid,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic        [LAG_W-1:0]  acc_lag,
  output logic                     acc_valid,
  output logic signed [ACC_W-1:0]  peak_val,
  output logic        [LAG_W-1:0]  peak_lag,
  output logic                     peak_valid,
  output logic                     busy
);

  localparam int               CNT_W    = clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [LAG_W-1:0] LAG_LAST = LAG_W'(NLAGS - 1);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [LAG_W-1:0] lag_q, lag_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic        [LAG_W-1:0] acc_lag_q, acc_lag_d;
  logic                    acc_valid_q, acc_valid_d;
  logic signed [ACC_W-1:0] peak_val_q, peak_val_d;
  logic        [LAG_W-1:0] peak_lag_q, peak_lag_d;
  logic                    peak_valid_q, peak_valid_d;

  prod_t                   prod_s;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] best_val;
  logic        [LAG_W-1:0] best_idx;
  logic                    clr_en;
  logic                    accept;
  logic                    lag_end;
  logic                    sweep_end;

  assign prod_s    = prod_in;
  assign prod_ext  = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
  assign acc_base  = (state_q == ACCUM) ? acc_q : '0;
  assign sum       = acc_base + prod_ext;

  // clr wins over a coincident product, which is dropped.
  assign clr_en    = en && clr;
  assign accept    = en && prod_valid && !clr;
  assign lag_end   = accept && (cnt_q == CNT_LAST);
  assign sweep_end = lag_end && (lag_q == LAG_LAST);

  xcorr_peak_track #(
    .ACC_W (ACC_W),
    .LAG_W (LAG_W)
  ) u_peak (
    .clk        (clk),
    .rst_n      (rst),
    .clr_i      (clr_en),
    .upd_i      (lag_end),
    .first_i    (lag_q == '0),
    .val_i      (sum),
    .idx_i      (lag_q),
    .best_val_o (best_val),
    .best_idx_o (best_idx)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (clr_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept)    state_d = ACCUM;
        ACCUM:   if (sweep_end) state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ACCUM);
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    lag_d        = lag_q;
    acc_out_d    = acc_out_q;
    acc_lag_d    = acc_lag_q;
    peak_val_d   = peak_val_q;
    peak_lag_d   = peak_lag_q;
    // Pulses default low every cycle, so they never stretch while en is low.
    acc_valid_d  = 1'b0;
    peak_valid_d = 1'b0;

    if (clr_en) begin
      acc_d = '0;
      cnt_d = '0;
      lag_d = '0;
    end else if (accept) begin
      if (lag_end) begin
        acc_d       = '0;
        cnt_d       = '0;
        lag_d       = sweep_end ? '0 : lag_q + LAG_W'(1);
        acc_out_d   = sum;
        acc_lag_d   = lag_q;
        acc_valid_d = 1'b1;
        if (sweep_end) begin
          peak_val_d   = best_val;
          peak_lag_d   = best_idx;
          peak_valid_d = 1'b1;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      lag_q        <= '0;
      acc_out_q    <= '0;
      acc_lag_q    <= '0;
      acc_valid_q  <= 1'b0;
      peak_val_q   <= '0;
      peak_lag_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      lag_q        <= lag_d;
      acc_out_q    <= acc_out_d;
      acc_lag_q    <= acc_lag_d;
      acc_valid_q  <= acc_valid_d;
      peak_val_q   <= peak_val_d;
      peak_lag_q   <= peak_lag_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign acc_out    = acc_out_q;
  assign acc_lag    = acc_lag_q;
  assign acc_valid  = acc_valid_q;
  assign peak_val   = peak_val_q;
  assign peak_lag   = peak_lag_q;
  assign peak_valid = peak_valid_q;

endmodule

// File: tb/tb_xcorr_lag_accum.sv
// Directed testbench for xcorr_lag_accum with WINDOW=4, NLAGS=3, ACC_W=18, LAG_W=2.
module tb_xcorr_lag_accum;

  localparam int WINDOW = 4;
  localparam int NLAGS  = 3;
  localparam int ACC_W  = 18;
  localparam int LAG_W  = 2;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    clr;
  logic signed [15:0]      prod_in;
  logic                    prod_valid;
  logic signed [ACC_W-1:0] acc_out;
  logic        [LAG_W-1:0] acc_lag;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] peak_val;
  logic        [LAG_W-1:0] peak_lag;
  logic                    peak_valid;
  logic                    busy;

  int n_checks;
  int n_pass;

  xcorr_lag_accum #(
    .WINDOW (WINDOW),
    .NLAGS  (NLAGS),
    .ACC_W  (ACC_W),
    .LAG_W  (LAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .acc_lag    (acc_lag),
    .acc_valid  (acc_valid),
    .peak_val   (peak_val),
    .peak_lag   (peak_lag),
    .peak_valid (peak_valid),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int p);
    prod_valid = 1'b1;
    prod_in    = 16'(p);
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_out"},    $signed(acc_out), 0);
    check({tag, "_acc_lag"},    acc_lag,          0);
    check({tag, "_acc_valid"},  acc_valid,        0);
    check({tag, "_peak_val"},   $signed(peak_val), 0);
    check({tag, "_peak_lag"},   peak_lag,         0);
    check({tag, "_peak_valid"}, peak_valid,       0);
    check({tag, "_busy"},       busy,             0);
  endtask

  // One contiguous lag of four products; the sum appears one edge after the last.
  task automatic lag4(input int p0, input int p1, input int p2, input int p3,
                      input int exp_sum, input int exp_lag, input int exp_pv);
    int p[4];
    p = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) begin
      feed(p[i]);
      if (i < 3) check("lag_mid_no_pulse", acc_valid, 0);
    end
    check("lag_acc_valid",  acc_valid,         1);
    check("lag_acc_out",    $signed(acc_out),  exp_sum);
    check("lag_acc_lag",    acc_lag,           exp_lag);
    check("lag_peak_valid", peak_valid,        exp_pv);
  endtask

  initial begin
    int gaps;
    int pv_cnt;
    int pv_first;
    int pv_second;

    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b0;
    en         = 1'b0;
    clr        = 1'b0;
    prod_valid = 1'b0;
    prod_in    = '0;

    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    en  = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // Basic sweep
    feed(1);
    check("basic_busy_after_first", busy, 1);
    feed(2); feed(3); feed(4);
    check("basic_l0_valid", acc_valid, 1);
    check("basic_l0_out",   $signed(acc_out), 10);
    check("basic_l0_lag",   acc_lag, 0);
    check("basic_l0_no_peak", peak_valid, 0);
    lag4(-5, -5, -5, -5, -20, 1, 0);
    lag4(100, 0, 0, 1, 101, 2, 1);
    check("basic_peak_val", $signed(peak_val), 101);
    check("basic_peak_lag", peak_lag, 2);
    check("basic_busy_end", busy, 0);
    tick();
    check("basic_acc_pulse_once",  acc_valid, 0);
    check("basic_peak_pulse_once", peak_valid, 0);
    check("basic_peak_hold",       $signed(peak_val), 101);

    // Tie and all-negative sums
    lag4(-2, -2, -2, -2, -8, 0, 0);
    lag4(-1, -1, -1, 0, -3, 1, 0);
    lag4(0, -3, 0, 0, -3, 2, 1);
    check("tie_peak_val", $signed(peak_val), -3);
    check("tie_peak_lag", peak_lag, 1);

    // Full-scale products with gaps and en-low cycles
    for (int n = 0; n < 12; n++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        if ($urandom_range(0, 1) == 1) begin
          en         = 1'b0;
          prod_valid = 1'b1;
          prod_in    = 16'sd5;
        end else begin
          prod_valid = 1'b0;
        end
        tick();
        en         = 1'b1;
        prod_valid = 1'b0;
        check("fs_gap_no_pulse", acc_valid, 0);
        check("fs_gap_busy", busy, (n > 0) ? 1 : 0);
      end
      feed(-32768);
      if (n % 4 == 3) begin
        check("fs_valid", acc_valid, 1);
        check("fs_out",   $signed(acc_out), -131072);
        check("fs_lag",   acc_lag, n / 4);
        check("fs_peak_valid", peak_valid, (n == 11) ? 1 : 0);
        en         = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 16'sd123;
        tick();
        en         = 1'b1;
        prod_valid = 1'b0;
        check("fs_en_low_no_stretch", acc_valid, 0);
        check("fs_en_low_hold_out",   $signed(acc_out), -131072);
      end else begin
        check("fs_no_pulse", acc_valid, 0);
      end
    end
    check("fs_peak_val", $signed(peak_val), -131072);
    check("fs_peak_lag", peak_lag, 0);
    check("fs_busy_end", busy, 0);

    // clr mid-lag
    for (int i = 0; i < 6; i++) begin
      feed(1);
      check("clr_pre_valid", acc_valid, (i == 3) ? 1 : 0);
    end
    check("clr_pre_out", $signed(acc_out), 4);
    clr        = 1'b1;
    prod_valid = 1'b1;
    prod_in    = 16'sd7;
    tick();
    clr        = 1'b0;
    prod_valid = 1'b0;
    check("clr_no_acc_pulse",  acc_valid, 0);
    check("clr_no_peak_pulse", peak_valid, 0);
    check("clr_busy",          busy, 0);
    check("clr_hold_acc_out",  $signed(acc_out), 4);
    check("clr_hold_acc_lag",  acc_lag, 0);
    check("clr_hold_peak_val", $signed(peak_val), -131072);
    check("clr_hold_peak_lag", peak_lag, 0);
    lag4(1, 1, 1, 1, 4, 0, 0);
    lag4(2, 2, 2, 2, 8, 1, 0);
    lag4(3, 0, 0, 0, 3, 2, 1);
    check("clr_sweep_peak_val", $signed(peak_val), 8);
    check("clr_sweep_peak_lag", peak_lag, 1);

    // Asynchronous reset between edges, mid-sweep
    feed(10);
    feed(10);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    #2 rst = 1'b1;
    tick();
    check("async_post_no_pulse", acc_valid, 0);
    check("async_post_busy",     busy, 0);
    lag4(10, 10, 10, 10, 40, 0, 0);
    lag4(-1, 2, -3, 4, 2, 1, 0);
    lag4(5, 5, 5, 5, 20, 2, 1);
    check("async_peak_val", $signed(peak_val), 40);
    check("async_peak_lag", peak_lag, 0);

    // Back-to-back sweeps
    tick();
    pv_cnt    = 0;
    pv_first  = -1;
    pv_second = -1;
    for (int i = 0; i < 24; i++) begin
      feed(i);
      check("b2b_acc_valid",  acc_valid,  (i % 4 == 3) ? 1 : 0);
      check("b2b_peak_valid", peak_valid, (i % 12 == 11) ? 1 : 0);
      if (i % 4 == 3) begin
        check("b2b_acc_out", $signed(acc_out), 4 * i - 6);
        check("b2b_acc_lag", acc_lag, (i / 4) % 3);
      end
      if (i == 11) begin
        check("b2b_peak1_val", $signed(peak_val), 38);
        check("b2b_peak1_lag", peak_lag, 2);
      end
      if (i == 12) check("b2b_busy_restart", busy, 1);
      if (peak_valid) begin
        pv_cnt++;
        if (pv_first < 0) pv_first = i;
        else pv_second = i;
      end
    end
    check("b2b_peak_count",   pv_cnt, 2);
    check("b2b_peak_spacing", pv_second - pv_first, 12);
    check("b2b_peak2_val",    $signed(peak_val), 86);
    check("b2b_peak2_lag",    peak_lag, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
